// File: rtl/ir_cmd_ctrl.sv
// NEC remote command controller: address filter, key-hold repeat
// handling and a 4-deep first-word-fall-through output queue.
module ir_cmd_ctrl #(
  parameter logic [7:0] DEV_ADDR    = 8'h57,
  parameter int         REPEAT_WIN  = 5_750_000,
  parameter int         REPEAT_SKIP = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ir_valid,
  input  logic [7:0] ir_addr,
  input  logic [7:0] ir_cmd,
  input  logic       ir_repeat,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_rpt,
  input  logic       cmd_ready,
  output logic       key_held,
  output logic [7:0] drop_cnt
);

  localparam int TW = (REPEAT_WIN > 1) ? $clog2(REPEAT_WIN) : 1;
  localparam int RW = (REPEAT_SKIP > 0) ? $clog2(REPEAT_SKIP + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(REPEAT_WIN - 1);
  localparam logic [RW-1:0] SKIP = RW'(REPEAT_SKIP);

  typedef enum logic {IDLE, HELD} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] rpt_cnt, rpt_n;
  logic [7:0]    last_cmd, last_n;
  logic          push;
  logic [8:0]    push_ent;
  logic          hit;

  assign hit = ir_valid && (ir_addr == DEV_ADDR);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      timer    <= '0;
      rpt_cnt  <= '0;
      last_cmd <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      rpt_cnt  <= rpt_n;
      last_cmd <= last_n;
    end
  end

  // An accepted frame beats everything; a repeat beats the timeout.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    rpt_n    = rpt_cnt;
    last_n   = last_cmd;
    push     = 1'b0;
    push_ent = {ir_cmd, 1'b0};
    if (hit) begin
      push    = 1'b1;
      last_n  = ir_cmd;
      timer_n = '0;
      rpt_n   = '0;
      state_n = HELD;
    end else if (state == HELD) begin
      if (ir_repeat) begin
        timer_n = '0;
        if (rpt_cnt >= SKIP) begin
          push     = 1'b1;
          push_ent = {last_cmd, 1'b1};
        end else begin
          rpt_n = rpt_cnt + RW'(1);
        end
      end else if (timer == T_LAST) begin
        timer_n = '0;
        state_n = IDLE;
      end else begin
        timer_n = timer + TW'(1);
      end
    end
  end

  assign key_held = (state == HELD);

  logic [8:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       pop, full, wr_en;

  assign full  = (count == 3'd4);
  assign pop   = cmd_valid && cmd_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, wr_en} - {2'b0, pop};
      if (push && full && !pop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= push_ent;
  end

  // Head is masked when empty so stale storage never reaches the pins.
  assign cmd_valid = (count != 3'd0);
  assign {cmd_data, cmd_rpt} = cmd_valid ? mem[rd_ptr] : 9'd0;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Bench for ir_cmd_ctrl: hold-window/queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ir_cmd_ctrl;

  localparam int W = 100;
  localparam int SKIP = 2;
  localparam logic [7:0] DEV = 8'h57;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_valid = 1'b0;
  logic [7:0] ir_addr = '0;
  logic [7:0] ir_cmd = '0;
  logic       ir_repeat = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_rpt;
  logic       cmd_ready = 1'b1;
  logic       key_held;
  logic [7:0] drop_cnt;

  int checks = 0;
  int passed = 0;

  ir_cmd_ctrl #(
    .DEV_ADDR(DEV),
    .REPEAT_WIN(W),
    .REPEAT_SKIP(SKIP)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .ir_valid(ir_valid),
    .ir_addr(ir_addr),
    .ir_cmd(ir_cmd),
    .ir_repeat(ir_repeat),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_rpt(cmd_rpt),
    .cmd_ready(cmd_ready),
    .key_held(key_held),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: key is held while fewer than W edges have passed since the
  // last accepted frame or honoured repeat; the queue is a plain queue.
  logic [8:0] mq[$];
  int         cyc = 0;
  int         last_evt = 0;
  bit         mheld = 0;
  int         mcnt = 0;
  logic [7:0] mlast = '0;
  int         mdrop = 0;

  always @(posedge clk or posedge rst) begin : model
    bit mpop, mpush, hit, hb;
    logic [8:0] ent;
    if (rst) begin
      mq.delete();
      mheld = 0;
      mcnt = 0;
      mlast = '0;
      mdrop = 0;
    end else begin
      mpop = (mq.size() > 0) && cmd_ready;
      hit = ir_valid && (ir_addr == DEV);
      hb = mheld && (cyc - last_evt < W);
      mpush = 0;
      ent = '0;
      cyc++;
      if (hit) begin
        mpush = 1;
        ent = {ir_cmd, 1'b0};
        mlast = ir_cmd;
        mcnt = 0;
        mheld = 1;
        last_evt = cyc;
      end else if (ir_repeat && hb) begin
        last_evt = cyc;
        if (mcnt >= SKIP) begin
          mpush = 1;
          ent = {mlast, 1'b1};
        end else begin
          mcnt++;
        end
      end
      if (mpop) mq.delete(0);
      if (mpush) begin
        if (mq.size() < 4) mq.push_back(ent);
        else if (mdrop < 255) mdrop++;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'd0;
    chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() > 0));
    chk("cmd_data", 32'(cmd_data), 32'(head[8:1]));
    chk("cmd_rpt", 32'(cmd_rpt), 32'(head[0]));
    chk("key_held", 32'(key_held),
        32'(mheld && (cyc - last_evt < W)));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
  end

  logic [8:0] seen[$];
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready)
      seen.push_back({cmd_data, cmd_rpt});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] c);
    ir_valid = 1'b1;
    ir_addr = a;
    ir_cmd = c;
    @(negedge clk);
    ir_valid = 1'b0;
  endtask

  task automatic rep();
    ir_repeat = 1'b1;
    @(negedge clk);
    ir_repeat = 1'b0;
  endtask

  task automatic frame_rep(input logic [7:0] a, input logic [7:0] c);
    ir_repeat = 1'b1;
    frame(a, c);
    ir_repeat = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_data", 32'(cmd_data), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    idle(2);

    frame(DEV, 8'h22);
    chk("first_valid", 32'(cmd_valid), 32'd1);
    chk("first_data", 32'(cmd_data), 32'h22);
    chk("first_rpt", 32'(cmd_rpt), 32'd0);
    chk("first_held", 32'(key_held), 32'd1);

    for (int i = 0; i < 4; i++) begin
      idle(49);
      rep();
    end
    idle(99);
    chk("held_w_minus_1", 32'(key_held), 32'd1);
    chk("rpt_entries", 32'(seen.size()), 32'd3);
    chk("rpt_entry1", 32'(seen[1]), 32'({8'h22, 1'b1}));
    chk("rpt_entry2", 32'(seen[2]), 32'({8'h22, 1'b1}));
    idle(1);
    chk("timeout_held", 32'(key_held), 32'd0);
    rep();
    idle(2);
    chk("idle_rep_valid", 32'(cmd_valid), 32'd0);
    chk("idle_rep_seen", 32'(seen.size()), 32'd3);

    frame(DEV, 8'h33);
    frame(8'h12, 8'h99);
    chk("foreign_held", 32'(key_held), 32'd1);
    idle(2);
    chk("foreign_valid", 32'(cmd_valid), 32'd0);
    chk("foreign_seen", 32'(seen.size()), 32'd4);

    frame(DEV, 8'h44);
    idle(99);
    rep();
    chk("timeout_vs_rep", 32'(key_held), 32'd1);
    rep();
    idle(2);
    frame_rep(DEV, 8'h55);
    idle(2);
    chk("valid_wins_seen", 32'(seen.size()), 32'd6);
    chk("valid_wins_ent", 32'(seen[5]), 32'({8'h55, 1'b0}));

    cmd_ready = 1'b0;
    for (int c = 1; c <= 6; c++) frame(DEV, 8'(c));
    chk("full_drop", 32'(drop_cnt), 32'd2);
    chk("full_head", 32'(cmd_data), 32'd1);
    idle(3);
    chk("stall_head", 32'(cmd_data), 32'd1);
    chk("stall_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    frame(DEV, 8'h07);
    chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
    idle(6);
    chk("drain_seen", 32'(seen.size()), 32'd11);
    chk("drain_0", 32'(seen[6]), 32'({8'h01, 1'b0}));
    chk("drain_1", 32'(seen[7]), 32'({8'h02, 1'b0}));
    chk("drain_2", 32'(seen[8]), 32'({8'h03, 1'b0}));
    chk("drain_3", 32'(seen[9]), 32'({8'h04, 1'b0}));
    chk("drain_4", 32'(seen[10]), 32'({8'h07, 1'b0}));

    cmd_ready = 1'b0;
    frame(DEV, 8'h61);
    frame(DEV, 8'h62);
    frame(DEV, 8'h63);
    chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
    chk("pre_rst_held", 32'(key_held), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("in_rst_valid", 32'(cmd_valid), 32'd0);
    chk("in_rst_data", 32'(cmd_data), 32'd0);
    chk("in_rst_held", 32'(key_held), 32'd0);
    chk("in_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("post_rst_valid", 32'(cmd_valid), 32'd0);
    chk("post_rst_held", 32'(key_held), 32'd0);
    cmd_ready = 1'b1;
    idle(3);
    chk("post_rst_seen", 32'(seen.size()), 32'd11);
    frame(DEV, 8'h70);
    chk("post_rst_frame", 32'(cmd_data), 32'h70);
    idle(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ir_cmd_ctrl.md
IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 8'h57: device address accepted from the NEC receiver.
REQ-002 Parameter REPEAT_WIN, default 5_750_000: repeat window in sys_clk cycles (115 ms at 50 MHz).
REQ-003 Parameter REPEAT_SKIP, default 2: leading repeat codes suppressed per key press.
REQ-004 sys_clk  in  1  system clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  asynchronous reset, active-high.
REQ-006 ir_valid  in  1  one-cycle pulse: new full NEC frame decoded.
REQ-007 ir_addr  in  8  decoded address; qualified by ir_valid.
REQ-008 ir_cmd  in  8  decoded command; qualified by ir_valid.
REQ-009 ir_repeat  in  1  one-cycle pulse: NEC repeat code decoded.
REQ-010 cmd_valid  out  1  output queue non-empty.
REQ-011 cmd_data  out  8  command at queue head.
REQ-012 cmd_rpt  out  1  head entry came from a repeat code.
REQ-013 cmd_ready  in  1  downstream accepts head entry.
REQ-014 key_held  out  1  controller in HELD state.
REQ-015 drop_cnt  out  8  saturating count of entries lost to queue full.

Function
REQ-016 The controller SHALL have two states, IDLE and HELD, plus a repeat timer and a repeat counter rpt_cnt.
REQ-017 ir_valid with ir_addr==DEV_ADDR SHALL push {ir_cmd,rpt=0}, latch ir_cmd as last_cmd, clear timer and rpt_cnt, and enter HELD, from either state.
REQ-018 ir_valid with ir_addr!=DEV_ADDR SHALL be ignored: no push, no state, timer or counter change.
REQ-019 ir_repeat in IDLE SHALL be ignored.
REQ-020 ir_repeat in HELD SHALL clear the timer; if rpt_cnt (pre-update) >= REPEAT_SKIP push {last_cmd,rpt=1}, else increment rpt_cnt.
REQ-021 In HELD the timer SHALL increment each cycle; on the cycle it equals REPEAT_WIN-1, with no ir_valid or ir_repeat, the state SHALL return to IDLE.
REQ-022 Simultaneous ir_valid and ir_repeat: ir_valid SHALL win; repeat discarded.
REQ-023 Simultaneous timeout and ir_repeat: repeat SHALL win; state stays HELD.
REQ-024 Output queue SHALL be a 4-entry first-word-fall-through FIFO of {cmd[7:0],rpt}; cmd_valid = not empty; cmd_data/cmd_rpt show head.
REQ-025 Pop SHALL occur when cmd_valid and cmd_ready are both 1; cmd_data/cmd_rpt SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-026 A push at edge N SHALL make cmd_valid=1 after edge N (one-cycle latency from ir_valid/ir_repeat pulse).
REQ-027 Push when full without pop SHALL drop the new entry and increment drop_cnt, saturating at 255.
REQ-028 Push and pop on the same cycle when full SHALL accept the push; no drop.
REQ-029 Push and pop on the same cycle when empty: entry SHALL be written, head not popped (pop requires cmd_valid).
REQ-030 FIFO pointers SHALL wrap modulo 4; occupancy 0..4 tracked with a 3-bit count.
REQ-031 key_held SHALL be 1 exactly when state is HELD.

Reset
REQ-032 sys_rst=1 SHALL immediately force: state IDLE, timer 0, rpt_cnt 0, last_cmd 0, FIFO empty, cmd_valid 0, cmd_data 0, cmd_rpt 0, key_held 0, drop_cnt 0.
REQ-033 Reset asserted mid-hold or with FIFO non-empty SHALL discard all queued entries; no output activity until after deassertion.

Verification (bench uses REPEAT_WIN=100, REPEAT_SKIP=2, DEV_ADDR=8'h57)
REQ-034 ir_valid, addr 8'h57, cmd 8'h22, cmd_ready=1 -> cmd_valid=1 next cycle with cmd_data=8'h22, cmd_rpt=0; key_held=1.
REQ-035 After REQ-034, four ir_repeat pulses 50 cycles apart -> first two suppressed, then two entries {8'h22,rpt=1}; key_held stays 1.
REQ-036 After last repeat, no input for 100 cycles -> key_held=0; subsequent ir_repeat produces no entry.
REQ-037 ir_valid with addr 8'h12 -> no cmd_valid, key_held unchanged.
REQ-038 cmd_ready=0, six accepted frames cmds 1..6 -> FIFO holds 1..4, drop_cnt=2; releasing cmd_ready yields 1,2,3,4 in order.
REQ-039 sys_rst pulsed while FIFO holds 3 entries and key_held=1 -> all outputs zero during and after reset until next accepted frame.
